// File: rtl/floating_point_onboard_checker.sv
// ---------------------------------------------------------------------------
// floating_point_onboard_checker
//
// Read-side sequencer for the onboard floating-point test ROMs. Walks the
// shared ROM address over NUM_VEC vectors, loads operand and expected result
// (both ROMs have a one-cycle registered read), hands the operand to the FP
// core under test with a valid/ready handshake, waits (bounded) for the
// result strobe and compares. Reports pass/fail, an error count and the
// address of the first failing vector.
//
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   start        one-cycle pulse; starts a run from IDLE or DONE
//   rom_addr     address to both ROMs, held from FETCH to the next FETCH
//   rom_a_dout   operand ROM data (valid one cycle after rom_addr)
//   rom_e_dout   expected-result ROM data (valid one cycle after rom_addr)
//   op_a         operand to the core under test
//   op_valid     operand valid; transfer on op_valid & op_ready
//   op_ready     core ready for the operand
//   res_data     result from the core
//   res_valid    single-cycle result strobe, only honoured in WAIT
//   busy         run in progress (not IDLE, not DONE)
//   done         run finished, status valid
//   pass         done with zero errors
//   err_cnt      mismatches + timeouts this run, saturating at 31
//   fail_addr    address of the first failing vector, 0 if none
//   timeout      sticky: some vector timed out this run
// ---------------------------------------------------------------------------
module floating_point_onboard_checker #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23,
  parameter int NUM_VEC   = 11,
  parameter int TIMEOUT   = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic [3:0]                     rom_addr,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]   rom_a_dout,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]   rom_e_dout,
  output logic [EXP_WIDTH+MAN_WIDTH:0]   op_a,
  output logic                           op_valid,
  input  logic                           op_ready,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]   res_data,
  input  logic                           res_valid,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [4:0]                     err_cnt,
  output logic [3:0]                     fail_addr,
  output logic                           timeout
);

  localparam int          DW         = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam logic [3:0]  LAST_IDX   = 4'(NUM_VEC - 1);
  // The counter starts at 0 on entry, so TIMEOUT cycles elapse when it
  // reaches TIMEOUT-1 without a result.
  localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t          state_q,     state_d;
  logic [3:0]      idx_q,       idx_d;
  logic [3:0]      rom_addr_q,  rom_addr_d;
  logic [DW-1:0]   op_a_q,      op_a_d;
  logic [DW-1:0]   exp_q,       exp_d;
  logic [DW-1:0]   res_q,       res_d;
  logic            op_valid_q,  op_valid_d;
  logic [15:0]     wait_cnt_q,  wait_cnt_d;
  logic            vec_tmo_q,   vec_tmo_d;
  logic [4:0]      err_cnt_q,   err_cnt_d;
  logic [3:0]      fail_addr_q, fail_addr_d;
  logic            timeout_q,   timeout_d;

  // NaN: exponent all ones and non-zero mantissa. Sign and payload are
  // don't-care, so any two NaNs compare equal.
  logic exp_is_nan;
  logic res_is_nan;
  logic vec_match;
  logic vec_fail;

  assign exp_is_nan = (&exp_q[DW-2:MAN_WIDTH]) && (|exp_q[MAN_WIDTH-1:0]);
  assign res_is_nan = (&res_q[DW-2:MAN_WIDTH]) && (|res_q[MAN_WIDTH-1:0]);
  assign vec_match  = (res_q == exp_q) || (exp_is_nan && res_is_nan);
  // A timed-out vector fails regardless of whatever res_q holds.
  assign vec_fail   = vec_tmo_q || !vec_match;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rom_addr_d  = rom_addr_q;
    op_a_d      = op_a_q;
    exp_d       = exp_q;
    res_d       = res_q;
    op_valid_d  = op_valid_q;
    wait_cnt_d  = wait_cnt_q;
    vec_tmo_d   = vec_tmo_q;
    err_cnt_d   = err_cnt_q;
    fail_addr_d = fail_addr_q;
    timeout_d   = timeout_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_FETCH;
          idx_d       = 4'd0;
          rom_addr_d  = 4'd0;
          err_cnt_d   = 5'd0;
          fail_addr_d = 4'd0;
          timeout_d   = 1'b0;
        end
      end

      // rom_addr already shows idx; the ROMs register it at the end of
      // this cycle.
      S_FETCH: state_d = S_LOAD;

      S_LOAD: begin
        op_a_d     = rom_a_dout;
        exp_d      = rom_e_dout;
        op_valid_d = 1'b1;
        state_d    = S_ISSUE;
      end

      S_ISSUE: begin
        if (op_ready) begin
          op_valid_d = 1'b0;
          wait_cnt_d = 16'd0;
          vec_tmo_d  = 1'b0;
          state_d    = S_WAIT;
        end
      end

      S_WAIT: begin
        if (res_valid) begin
          res_d   = res_data;
          state_d = S_CHECK;
        end else if (wait_cnt_q == WAIT_LIMIT) begin
          vec_tmo_d = 1'b1;
          timeout_d = 1'b1;
          state_d   = S_CHECK;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end

      S_CHECK: begin
        if (vec_fail) begin
          if (err_cnt_q != 5'd31) begin
            err_cnt_d = err_cnt_q + 5'd1;
          end
          // err_cnt saturates and never wraps to 0, so zero means
          // "no earlier failure in this run".
          if (err_cnt_q == 5'd0) begin
            fail_addr_d = idx_q;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d      = idx_q + 4'd1;
          rom_addr_d = idx_q + 4'd1;
          state_d    = S_FETCH;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= 4'd0;
      rom_addr_q  <= 4'd0;
      op_a_q      <= '0;
      exp_q       <= '0;
      res_q       <= '0;
      op_valid_q  <= 1'b0;
      wait_cnt_q  <= 16'd0;
      vec_tmo_q   <= 1'b0;
      err_cnt_q   <= 5'd0;
      fail_addr_q <= 4'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rom_addr_q  <= rom_addr_d;
      op_a_q      <= op_a_d;
      exp_q       <= exp_d;
      res_q       <= res_d;
      op_valid_q  <= op_valid_d;
      wait_cnt_q  <= wait_cnt_d;
      vec_tmo_q   <= vec_tmo_d;
      err_cnt_q   <= err_cnt_d;
      fail_addr_q <= fail_addr_d;
      timeout_q   <= timeout_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign op_a      = op_a_q;
  assign op_valid  = op_valid_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign pass      = (state_q == S_DONE) && (err_cnt_q == 5'd0);
  assign err_cnt   = err_cnt_q;
  assign fail_addr = fail_addr_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_floating_point_onboard_checker.sv
// ---------------------------------------------------------------------------
// tb_floating_point_onboard_checker
//
// Directed runs of the ROM checker against a behavioural ROM pair and a
// loopback FP core (3-cycle latency) whose answers can be corrupted per
// vector. Stimulus pushes expected operands and expected end-of-run status
// into queues; an independent monitor pops and compares whenever the DUT
// transfers an operand or raises done.
// ---------------------------------------------------------------------------
module tb_floating_point_onboard_checker;

  localparam int NV = 11;
  localparam int TO = 8;

  typedef struct packed {
    logic       pass;
    logic [4:0] err;
    logic [3:0] fa;
    logic       to;
  } st_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  rom_addr;
  logic [31:0] rom_a_dout;
  logic [31:0] rom_e_dout;
  logic [31:0] op_a;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] res_data;
  logic        res_valid;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  err_cnt;
  logic [3:0]  fail_addr;
  logic        timeout;

  floating_point_onboard_checker #(
    .EXP_WIDTH (8),
    .MAN_WIDTH (23),
    .NUM_VEC   (NV),
    .TIMEOUT   (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rom_addr   (rom_addr),
    .rom_a_dout (rom_a_dout),
    .rom_e_dout (rom_e_dout),
    .op_a       (op_a),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_cnt    (err_cnt),
    .fail_addr  (fail_addr),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] rom_a [16];
  logic [31:0] rom_e [16];

  // Core corruption controls, set by the stimulus before each run.
  logic [15:0] flip_mask = 16'h0;
  logic [15:0] drop_mask = 16'h0;
  logic        nan_alt   = 1'b0;
  logic        inf_bad   = 1'b0;
  logic        ready_low = 1'b0;

  logic [31:0] exp_op_q [$];
  st_t         exp_st_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ROM pair + loopback core. Address/handshake are sampled on the
  // negedge before the rising edge they take effect at; outputs change
  // 1 time unit after the edge.
  initial begin
    logic        hs;
    logic [3:0]  a;
    int          cnt;
    logic [31:0] pend;
    cnt        = 0;
    pend       = '0;
    op_ready   = 1'b1;
    res_valid  = 1'b0;
    res_data   = '0;
    rom_a_dout = '0;
    rom_e_dout = '0;
    forever begin
      @(negedge clk);
      hs = op_valid && op_ready;
      a  = rom_addr;
      @(posedge clk);
      #1;
      rom_a_dout = rom_a[a];
      rom_e_dout = rom_e[a];
      res_valid  = 1'b0;
      if (rst) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            res_valid = 1'b1;
            res_data  = pend;
          end
        end
        if (hs && !drop_mask[a]) begin
          cnt  = 3;
          pend = rom_e[a];
          if (flip_mask[a])       pend = pend ^ 32'h1;
          if (a == 4'd7 && nan_alt) pend = 32'h7FC0_0001;
          if (a == 4'd7 && inf_bad) pend = 32'h7F80_0000;
        end
      end
      op_ready = !(ready_low && rom_addr == 4'd2);
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic        done_prev;
    logic [31:0] eo;
    st_t         es;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        done_prev = 1'b0;
      end else begin
        chk("busy_and_done", {31'd0, busy && done}, 32'd0);
        if (op_valid && op_ready) begin
          $display("op  addr=%0d op_a=%h", rom_addr, op_a);
          if (exp_op_q.size() == 0) begin
            chk("op_unexpected", 32'd1, 32'd0);
          end else begin
            eo = exp_op_q.pop_front();
            chk("op_a", op_a, eo);
          end
        end
        if (done && !done_prev) begin
          $display("run done pass=%0d err_cnt=%0d fail_addr=%0d timeout=%0d",
                   pass, err_cnt, fail_addr, timeout);
          if (exp_st_q.size() == 0) begin
            chk("status_unexpected", 32'd1, 32'd0);
          end else begin
            es = exp_st_q.pop_front();
            chk("pass",      {31'd0, pass},      {31'd0, es.pass});
            chk("err_cnt",   {27'd0, err_cnt},   {27'd0, es.err});
            chk("fail_addr", {28'd0, fail_addr}, {28'd0, es.fa});
            chk("timeout",   {31'd0, timeout},   {31'd0, es.to});
          end
        end
        done_prev = done;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctl"}, {15'd0, rom_addr, op_valid, busy, done, pass, err_cnt, fail_addr, timeout}, 32'd0);
    chk({tag, "_op_a"}, op_a, 32'd0);
  endtask

  // Queue expectations, pulse start, check first-issue latency and address.
  task automatic begin_run(input st_t es);
    int n;
    for (int i = 0; i < NV; i++) exp_op_q.push_back(rom_a[i]);
    exp_st_q.push_back(es);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (op_valid) begin
        n = k;
        break;
      end
    end
    chk("first_valid_latency", n, 32'd3);
    chk("first_rom_addr", {28'd0, rom_addr}, 32'd0);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_reached", {31'd0, seen}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int n;
    bit seen;
    logic [31:0] held;
    for (int i = 0; i < 16; i++) begin
      rom_a[i] = 32'h4100_0000 + 32'(i) * 32'h0010_0000;
      rom_e[i] = 32'h4200_0000 + 32'(i) * 32'h0008_0001;
    end
    rom_e[7] = 32'h7FC0_0000;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // 1: clean loopback
    begin_run(st_t'{1'b1, 5'd0, 4'd0, 1'b0});
    wait_done();

    // 2: LSB flipped at vectors 3 and 6
    flip_mask = 16'h0048;
    begin_run(st_t'{1'b0, 5'd2, 4'd3, 1'b0});
    wait_done();
    flip_mask = 16'h0;

    // 3: different NaN payload at vector 7 is still a match
    nan_alt = 1'b1;
    begin_run(st_t'{1'b1, 5'd0, 4'd0, 1'b0});
    wait_done();
    nan_alt = 1'b0;

    // 3b: infinity where NaN is expected is a mismatch
    inf_bad = 1'b1;
    begin_run(st_t'{1'b0, 5'd1, 4'd7, 1'b0});
    wait_done();
    inf_bad = 1'b0;

    // 4: vector 0 never answers; 8 WAIT cycles, then CHECK, then FETCH 1
    drop_mask = 16'h0001;
    begin_run(st_t'{1'b0, 5'd1, 4'd0, 1'b1});
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rom_addr == 4'd1) begin
        n = k;
        break;
      end
    end
    chk("timeout_exit_cycles", n, 32'd10);
    wait_done();
    drop_mask = 16'h0;

    // 5: op_ready held low at vector 2
    ready_low = 1'b1;
    begin_run(st_t'{1'b1, 5'd0, 4'd0, 1'b0});
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (op_valid && rom_addr == 4'd2) begin
        seen = 1'b1;
        break;
      end
    end
    chk("stall_reached", {31'd0, seen}, 32'd1);
    held = op_a;
    chk("stall_op_a_value", held, rom_a[2]);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("stall_hold", {op_valid, 27'd0, rom_addr}, {1'b1, 27'd0, 4'd2});
      chk("stall_op_a", op_a, held);
    end
    ready_low = 1'b0;
    wait_done();

    // 6: reset in WAIT of vector 3 after a failure at vector 1
    flip_mask = 16'h0002;
    begin_run(st_t'{1'b0, 5'd1, 4'd1, 1'b0});
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (op_valid && rom_addr == 4'd3) begin
        seen = 1'b1;
        break;
      end
    end
    chk("abort_point_reached", {31'd0, seen}, 32'd1);
    @(negedge clk);
    chk("pre_reset_err_cnt", {27'd0, err_cnt}, 32'd1);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1 check_all_zero("async_reset");
    exp_op_q.delete();
    exp_st_q.delete();
    flip_mask = 16'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    begin_run(st_t'{1'b1, 5'd0, 4'd0, 1'b0});
    repeat (10) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();

    chk("op_queue_empty", exp_op_q.size(), 32'd0);
    chk("status_queue_empty", exp_st_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global guard against a hung run.
  initial begin
    #500000;
    $display("FAIL global_timeout: got hang, expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule
